// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random word generator: FSM encoding,
// default feedback mask / seed, and a parity helper for the feedback XOR.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    localparam logic [15:0] LFSR_DEFAULT_TAPS = 16'hD008;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // XOR of all state bits selected by the tap mask (zero-extended to 32 bits).
    function automatic logic tap_parity(input logic [31:0] state, input logic [31:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register: feedback, step, seed load and recovery
// from the all-zero lock-up state.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(LFSR_DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(LFSR_DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic             fb,
    output logic             lockup
);

    logic [WIDTH-1:0] r_state;
    logic             r_lockup;
    logic             w_fb;
    logic [WIDTH-1:0] w_shifted;

    assign w_fb      = tap_parity(32'(r_state), 32'(TAPS));
    assign w_shifted = {r_state[WIDTH-2:0], w_fb};
    assign fb        = w_fb;
    assign lockup    = r_lockup;

    // State update: load beats zero recovery, which beats a normal step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= DEFAULT_SEED;
            r_lockup <= 1'b0;
        end else if (load) begin
            if (seed == '0) begin
                r_state  <= DEFAULT_SEED;
                r_lockup <= 1'b1;
            end else begin
                r_state  <= seed;
                r_lockup <= 1'b0;
            end
        end else if (r_state == '0) begin
            r_state  <= DEFAULT_SEED;
            r_lockup <= 1'b1;
        end else if (step) begin
            r_state  <= w_shifted;
            r_lockup <= 1'b0;
        end else begin
            r_lockup <= 1'b0;
        end
    end

endmodule

// File: rtl/lfsr_random.sv
// Random word generator: free-running LFSR plus a request FSM that shifts
// OUT_BITS consecutive feedback bits into rnd and flags completion with valid.
module lfsr_random
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(LFSR_DEFAULT_TAPS),
    parameter int               OUT_BITS     = 8,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(LFSR_DEFAULT_SEED)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [WIDTH-1:0]    seed,
    input  logic                en,
    input  logic                req,
    output logic                q,
    output logic [OUT_BITS-1:0] rnd,
    output logic                valid,
    output logic                busy,
    output logic                lockup
);

    localparam int            CW   = $clog2(OUT_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(OUT_BITS - 1);

    generate
        if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
            $error("lfsr_random: WIDTH must be in 3..32");
        end
        if (OUT_BITS < 1 || OUT_BITS > WIDTH) begin : g_bad_out_bits
            $error("lfsr_random: OUT_BITS must be in 1..WIDTH");
        end
        if (DEFAULT_SEED == '0) begin : g_bad_seed
            $error("lfsr_random: DEFAULT_SEED must be non-zero");
        end
    endgenerate

    fsm_state_t          r_fsm;
    logic [CW-1:0]       r_count;
    logic [OUT_BITS-1:0] r_rnd;
    logic                r_valid;
    logic                r_busy;
    logic                w_fb;
    logic                w_step;
    logic [OUT_BITS-1:0] w_rnd_next;

    // The LFSR advances while generating, or when free-running in IDLE with no
    // request pending; load overrides inside the core anyway.
    assign w_step = ~load & ((r_fsm == IDLE & ~req & en) | (r_fsm == GEN));

    generate
        if (OUT_BITS == 1) begin : g_rnd_one
            assign w_rnd_next = w_fb;
        end else begin : g_rnd_shift
            assign w_rnd_next = {r_rnd[OUT_BITS-2:0], w_fb};
        end
    endgenerate

    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAPS         (TAPS),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .seed   (seed),
        .step   (w_step),
        .fb     (w_fb),
        .lockup (lockup)
    );

    assign q     = w_fb;
    assign rnd   = r_rnd;
    assign valid = r_valid;
    assign busy  = r_busy;

    // Request FSM with registered valid/busy; load aborts any request in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm   <= IDLE;
            r_count <= '0;
            r_rnd   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else if (load) begin
            r_fsm   <= IDLE;
            r_count <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    r_valid <= 1'b0;
                    if (req) begin
                        r_fsm   <= GEN;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                GEN: begin
                    r_rnd  <= w_rnd_next;
                    r_busy <= 1'b1;
                    if (r_count == LAST) begin
                        r_fsm   <= DONE;
                        r_count <= '0;
                        r_valid <= 1'b1;
                    end else begin
                        r_count <= r_count + CW'(1);
                        r_valid <= 1'b0;
                    end
                end
                DONE: begin
                    r_fsm   <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_fsm   <= IDLE;
                    r_count <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lfsr_random.md
LFSR_RANDOM -- requirements
Module: lfsr_random

Interface
REQ-001 Parameter WIDTH, default 16: LFSR state width, legal range 3..32.
REQ-002 Parameter TAPS, default 16'hD008: feedback mask; bit i set means state[i] feeds the XOR.
REQ-003 Parameter OUT_BITS, default 8: bits per random word, legal range 1..WIDTH.
REQ-004 Parameter DEFAULT_SEED, default 16'hACE1: non-zero reset and recovery value.
REQ-005 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-low.
REQ-007 Port load, input, 1: loads seed into the state register.
REQ-008 Port seed, input, WIDTH: seed value.
REQ-009 Port en, input, 1: free-run step enable.
REQ-010 Port req, input, 1: request one OUT_BITS-bit word.
REQ-011 Port q, output, 1: current feedback bit.
REQ-012 Port rnd, output, OUT_BITS: last completed random word.
REQ-013 Port valid, output, 1: one-cycle pulse when rnd is updated.
REQ-014 Port busy, output, 1: high while a request is in progress.
REQ-015 Port lockup, output, 1: one-cycle pulse when a zero state or zero seed is replaced.

Function
REQ-016 Feedback fb SHALL be the XOR of state[i] over all i set in TAPS; q = fb, combinational from the state register.
REQ-017 One step SHALL be state <= {state[WIDTH-2:0], fb} (Fibonacci, shift toward MSB).
REQ-018 The FSM SHALL have three states: IDLE, GEN and DONE.
REQ-019 IDLE: if req=1, go to GEN with count=0; else if en=1, perform one step; else hold.
REQ-020 GEN: each cycle, perform one step, set rnd <= {rnd[OUT_BITS-2:0], fb} and increment count; the step with count=OUT_BITS-1 moves to DONE.
REQ-021 DONE: valid=1 for exactly one cycle, then unconditionally return to IDLE.
REQ-022 req sampled at edge k SHALL give valid high in the cycle after edge k+OUT_BITS.
REQ-023 busy SHALL be 1 in GEN and DONE, and 0 in IDLE.
REQ-024 req SHALL be ignored in GEN and DONE; en SHALL be ignored outside IDLE.
REQ-025 load SHALL have priority over all other actions in every state.
REQ-026 On load: state <= seed, FSM goes to IDLE, count clears, rnd holds, and no valid is issued (an in-flight request is aborted).
REQ-027 Load with seed=0: state <= DEFAULT_SEED and lockup pulses for one cycle.
REQ-028 If state==0 at any edge without load: state <= DEFAULT_SEED and lockup pulses for one cycle.
REQ-029 rnd SHALL change only during GEN steps; the value is stable from valid until the next GEN.
REQ-030 count width SHALL be $clog2(OUT_BITS+1); count never exceeds OUT_BITS-1.

Reset
REQ-031 While rst=0: state=DEFAULT_SEED, FSM=IDLE, count=0, rnd=0, valid=0, busy=0, lockup=0.
REQ-032 Reset asserted mid-GEN SHALL abort immediately; no valid follows reset release.
REQ-033 The first action SHALL occur on the first rising edge after rst deasserts.

Structure
REQ-034 Package lfsr_pkg SHALL hold the FSM state enum (IDLE, GEN, DONE) and the default constants for TAPS and DEFAULT_SEED.
REQ-035 Sub-module lfsr_core SHALL contain the state register, feedback, step/load/zero-recovery logic, and the fb output; lfsr_random holds the FSM, count and rnd.
REQ-036 Compile-time check: DEFAULT_SEED != 0 and OUT_BITS <= WIDTH.

Verification (WIDTH=4, TAPS=4'hC, OUT_BITS=4, DEFAULT_SEED=4'h1)
REQ-037 Reset, then en=1 for 15 cycles: state follows 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8, then returns to 1 (period 15).
REQ-038 Load 4'h1, then a one-cycle req: busy for 5 cycles; valid pulses 4 cycles after the req edge with rnd=4'h3 and state=4'h3.
REQ-039 Load seed 0: state=4'h1 and lockup=1 for one cycle; a second req holds during GEN and is ignored.
REQ-040 req, then load 4'h9 on the second GEN cycle: no valid, rnd unchanged, state=4'h9, FSM in IDLE.
REQ-041 rst pulled low mid-GEN: all outputs go to reset values asynchronously; no valid after release.
REQ-042 Default parameters (WIDTH=16), seed 16'hACE1, en for 65535 cycles: state returns to 16'hACE1 with no zero state and lockup never pulsed.
